// File: rtl/timer_pkg.sv
// Shared register map, CTRL bit layout and ID constants for the timer_bank peripheral.
package timer_pkg;

    localparam int unsigned ChStride = 16;

    // Enum value is the register's byte offset within a channel block, divided by 4.
    typedef enum logic [1:0] {
        RegCtrl   = 2'd0,
        RegThresh = 2'd1,
        RegCount  = 2'd2,
        RegEvents = 2'd3
    } ch_reg_e;

    localparam logic [7:0] OffPresc = 8'h80;
    localparam logic [7:0] OffId    = 8'h84;

    localparam int unsigned CtrlW       = 3;
    localparam int unsigned CtrlEn      = 0;
    localparam int unsigned CtrlOneshot = 1;
    localparam int unsigned CtrlIrqEn   = 2;

    localparam logic [15:0] IdMagic = 16'h7100;

    function automatic logic [31:0] id_value(input int unsigned n_ch, input int unsigned cnt_w);
        logic [31:0] n;
        logic [31:0] w;
        n = n_ch;
        w = cnt_w;
        return {IdMagic, n[7:0], w[7:0]};
    endfunction

endpackage

// File: rtl/timer_channel.sv
// One timer channel: CTRL, THRESH, COUNT, event counter and sticky pending flag.
module timer_channel
    import timer_pkg::*;
#(
    parameter int unsigned      CNT_W      = 32,
    parameter int unsigned      EVW        = 31,
    parameter logic [CNT_W-1:0] THRESH_RST = CNT_W'(32'h0001_0000)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             wr_ctrl,
    input  logic             wr_thresh,
    input  logic             wr_count,
    input  logic             wr_events,
    input  logic [CNT_W-1:0] wdata,
    output logic [CtrlW-1:0] ctrl,
    output logic [CNT_W-1:0] thresh,
    output logic [CNT_W-1:0] count,
    output logic [EVW-1:0]   events,
    output logic             pending,
    output logic             irq
);

    logic [CtrlW-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0] thresh_q, thresh_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [EVW-1:0]   events_q, events_d;
    logic             pending_q, pending_d;

    logic run, thr_zero, fire;

    // A COUNT write swallows the tick for this edge, including any event it would raise.
    assign run      = tick && ctrl_q[CtrlEn] && !wr_count;
    assign thr_zero = (thresh_q == '0);
    assign fire     = run && !thr_zero && (count_q >= thresh_q);

    always_comb begin
        ctrl_d    = ctrl_q;
        thresh_d  = thresh_q;
        count_d   = count_q;
        events_d  = events_q;
        pending_d = pending_q;

        if (wr_thresh) begin
            thresh_d = wdata;
        end

        if (wr_count) begin
            count_d = '0;
        end else if (run) begin
            count_d = (thr_zero || fire) ? '0 : count_q + CNT_W'(1);
        end

        if (wr_events) begin
            events_d  = '0;
            pending_d = 1'b0;
        end else if (fire) begin
            events_d  = events_q + EVW'(1);
            pending_d = 1'b1;
        end

        // A CTRL write overrides the one-shot auto-disable on the same edge.
        if (wr_ctrl) begin
            ctrl_d = wdata[CtrlW-1:0];
        end else if (fire && ctrl_q[CtrlOneshot]) begin
            ctrl_d[CtrlEn] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_q    <= '0;
            thresh_q  <= THRESH_RST;
            count_q   <= '0;
            events_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            ctrl_q    <= ctrl_d;
            thresh_q  <= thresh_d;
            count_q   <= count_d;
            events_q  <= events_d;
            pending_q <= pending_d;
        end
    end

    assign ctrl    = ctrl_q;
    assign thresh  = thresh_q;
    assign count   = count_q;
    assign events  = events_q;
    assign pending = pending_q;
    assign irq     = pending_q && ctrl_q[CtrlIrqEn];

endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of timer channels sharing one prescaler; holds decode and read mux.
module timer_bank
    import timer_pkg::*;
#(
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CNT_W      = 32,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_F100,
    parameter logic [31:0] THRESH_RST = 32'h0001_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     addr,
    input  logic            we,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata,
    output logic [N_CH-1:0] irq
);

    // At full width bit 31 of EVENTS is the pending flag, leaving 31 bits of count.
    localparam int unsigned EVW     = (CNT_W == 32) ? 31 : CNT_W;
    localparam int unsigned CH_SPAN = N_CH * ChStride;

    logic       hit, ch_space;
    logic [7:0] off;
    logic [2:0] ch_sel;
    ch_reg_e    reg_sel;

    assign off      = {addr[7:2], 2'b00};
    assign hit      = (addr[31:8] == BASE_ADDR[31:8]);
    assign ch_space = hit && (32'(off) < CH_SPAN);
    assign ch_sel   = off[6:4];
    assign reg_sel  = ch_reg_e'(off[3:2]);

    logic [CNT_W-1:0] cw;
    assign cw = wdata[CNT_W-1:0];

    logic [CNT_W-1:0] presc_q, pcnt_q;
    logic             presc_wr, tick;

    assign presc_wr = we && hit && (off == OffPresc);
    assign tick     = (pcnt_q == presc_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_q <= '0;
            pcnt_q  <= '0;
        end else if (presc_wr) begin
            presc_q <= cw;
            pcnt_q  <= '0;
        end else if (tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + CNT_W'(1);
        end
    end

    logic [CtrlW-1:0] ch_ctrl   [N_CH];
    logic [CNT_W-1:0] ch_thresh [N_CH];
    logic [CNT_W-1:0] ch_count  [N_CH];
    logic [EVW-1:0]   ch_events [N_CH];
    logic [N_CH-1:0]  ch_pending;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic sel;
        assign sel = we && ch_space && (ch_sel == 3'(i));

        timer_channel #(
            .CNT_W      (CNT_W),
            .EVW        (EVW),
            .THRESH_RST (THRESH_RST[CNT_W-1:0])
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .wr_ctrl   (sel && (reg_sel == RegCtrl)),
            .wr_thresh (sel && (reg_sel == RegThresh)),
            .wr_count  (sel && (reg_sel == RegCount)),
            .wr_events (sel && (reg_sel == RegEvents)),
            .wdata     (cw),
            .ctrl      (ch_ctrl[i]),
            .thresh    (ch_thresh[i]),
            .count     (ch_count[i]),
            .events    (ch_events[i]),
            .pending   (ch_pending[i]),
            .irq       (irq[i])
        );
    end

    always_comb begin
        rdata = '0;
        if (!rst && hit) begin
            if (ch_space) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (ch_sel == 3'(i)) begin
                        unique case (reg_sel)
                            RegCtrl:   rdata = 32'(ch_ctrl[i]);
                            RegThresh: rdata = 32'(ch_thresh[i]);
                            RegCount:  rdata = 32'(ch_count[i]);
                            RegEvents: rdata = {ch_pending[i], 31'(ch_events[i])};
                        endcase
                    end
                end
            end else if (off == OffPresc) begin
                rdata = 32'(presc_q);
            end else if (off == OffId) begin
                rdata = id_value(N_CH, CNT_W);
            end
        end
    end

    logic unused_bits;
    assign unused_bits = ^{addr[1:0], wdata};

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Memory-mapped multi-channel timer peripheral on the CPU data bus, beside the other MMIO devices.
- N_CH independent channels share one programmable prescaler.
- Each channel has:
  - a writable threshold;
  - periodic or one-shot mode;
  - a free-running event counter;
  - a sticky interrupt-pending flag.
- Per-channel interrupt outputs go to the core.

Parameters:
- N_CH, 2, number of timer channels (1..8).
- CNT_W, 32, width of count, threshold, event and prescaler registers (8..32).
- BASE_ADDR, 32'hFFFF_F100, base of the 256-byte register window.
- THRESH_RST, 32'h0001_0000, reset value of every THRESH register; truncated to CNT_W.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  32  byte address from core; bits [1:0] ignored.
- we  in  1  write strobe; one write per cycle, applied at posedge clk.
- wdata  in  32  write data; low CNT_W bits used.
- rdata  out  32  combinational read data; zero-extended from CNT_W.
- irq  out  N_CH  per-channel level interrupt: pending[i] & CTRL[i].irq_en.

Behaviour:
- Window hit: addr[31:8] == BASE_ADDR[31:8]. No hit: writes ignored, rdata = 0.
- Channel i register map, at offset 16*i:
  - +0x0 CTRL, RW: bit0 en, bit1 oneshot, bit2 irq_en. Other bits read 0. Reset 0.
  - +0x4 THRESH, RW. Reset THRESH_RST.
  - +0x8 COUNT, R. Any write sets COUNT to 0.
  - +0xC EVENTS, R, bit31 = pending (CNT_W<32: bits [CNT_W-1:0] = events). Any write clears events and pending.
- Global registers:
  - offset 0x80 PRESC, RW, reset 0.
  - offset 0x84 ID, R, value {16'h7100, 8'(N_CH), 8'(CNT_W)}.
- Other offsets: read 0, write ignored.
- Prescaler:
  - pcnt counts 0..PRESC, then wraps to 0.
  - tick = 1 in the cycle pcnt == PRESC. With PRESC = 0, tick = 1 every cycle.
  - Writing PRESC also clears pcnt.
- Channel update, on a cycle with tick & en:
  - If THRESH == 0: COUNT holds at 0, no event.
  - Else if COUNT >= THRESH: COUNT <= 0; events <= events+1 (wraps at 2^(CNT_W-1) when CNT_W = 32, else at 2^CNT_W); pending <= 1. If oneshot, en <= 0 in the same edge.
  - Else: COUNT <= COUNT+1.
- Period is (THRESH+1)*(PRESC+1) clk cycles.
- en = 0: COUNT, events and pending hold.
- Writing THRESH below the current COUNT fires an event on the next tick.
- Simultaneous bus write and tick on the same register: the bus write wins.
  - COUNT write: COUNT = 0, tick ignored for that edge.
  - EVENTS write: cleared; an event at that edge is lost, but COUNT still wraps.
  - CTRL write: new CTRL value wins over the oneshot auto-clear.
- Writing CTRL.en from 0 to 1 does not reset COUNT.
- rst asserted mid-operation: all registers to reset values immediately, irq = 0, rdata = 0.

Decomposition:
- Shared package / defines header (timer_pkg):
  - register offsets: CTRL 0x0, THRESH 0x4, COUNT 0x8, EVENTS 0xC, PRESC 0x80, ID 0x84;
  - CTRL bit indices;
  - channel stride 16;
  - ID magic 16'h7100.
- Sub-module timer_channel: one channel's CTRL/THRESH/COUNT/EVENTS/pending logic, with inputs tick, per-register write strobes and wdata. timer_bank instantiates N_CH copies via generate and holds the prescaler, address decode and read mux.

Test Plan:
- Reset check: after rst, THRESH0 = 0x10000, CTRL0 = 0, PRESC = 0, irq = 0. Read 0xFFFFF184 gives 0x71000220 (N_CH = 2, CNT_W = 32).
- Periodic: THRESH0 = 4, PRESC = 0, CTRL0 = 0x5. EVENTS0 increments every 5 cycles. irq[0] rises 5 cycles after en and stays high. Write EVENTS0 -> 0 and irq[0] = 0 the next cycle.
- Prescaled one-shot: PRESC = 2, THRESH1 = 3, CTRL1 = 0x3. Exactly one event at cycle 12. CTRL1 then reads 0x2; COUNT1 reads 0 and stays 0.
- Threshold shrink: THRESH0 = 100, run until COUNT0 = 50, write THRESH0 = 10. Event on the next tick, COUNT0 = 0.
- Collision: write COUNT0 in the same cycle as an event tick. COUNT0 = 0, no event counted for that edge. Write CTRL0 = 0x1 in the oneshot-fire cycle: en stays 1.
- Async reset mid-run: assert rst between clock edges while irq = 1. irq and rdata go to 0 without a clock edge.
